pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised inter-stage pipeline register for the MIPS core, replacing hand-written per-stage registers (ID/EX, EX/MEM, MEM/WB). It carries a control bundle (write/read enables) and a data bundle (PC, operands, result, destination) between stages. It uses a valid/ready handshake, a synchronous flush for hazard and branch squashing, and an optional 2-entry skid mode that registers the backpressure path. It also keeps saturating stall and bubble counters for performance analysis.

## Interface
Parameters:
- CTRL_W, default 3: control bundle width (e.g. WB_En, MEM_R_En, MEM_W_En); forced to 0 in bubbles.
- DATA_W, default 133: data bundle width (e.g. dest 5 + PC 32 + readdata 32 + Immediate 32 + ALU result 32).
- SKID, default 0: 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready.
- CNT_W, default 16: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control bundle; 0 whenever out_valid=0.
- out_data  out  DATA_W  data bundle; holds its last value when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0.

## Operation
- Handshake: a beat transfers on the input side when in_valid and in_ready are both 1, and on the output side when out_valid and out_ready are both 1.
- Beats leave in arrival order. No beat is duplicated or lost except by flush.
- SKID=0, states EMPTY and FULL:
  - in_ready = !out_valid | out_ready.
  - EMPTY to FULL on accept.
  - FULL stays FULL on simultaneous accept and drain (the register is overwritten).
  - FULL to EMPTY on drain without accept.
- SKID=1, states EMPTY, ONE, TWO (main register plus skid register):
  - in_ready = (state != TWO), driven directly from a flop.
  - EMPTY to ONE on accept.
  - ONE to TWO on accept without drain (the beat goes to the skid register).
  - ONE stays ONE on simultaneous accept and drain.
  - ONE to EMPTY on drain only.
  - TWO to ONE on drain: the skid register moves to main in the same edge, and there is no accept because in_ready=0.
- Flush: on the next edge, every state goes to EMPTY and out_valid=0.
  - A beat offered in the same cycle as flush is dropped, even if in_ready=1.
  - out_data is not cleared by flush.
- Priority, highest first: rst, flush, then handshake.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1.
  - Flush does not clear them; only rst does.
  - Counting is based on pre-edge signal values; a flush cycle counts normally.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on out_* after edge N, i.e. during cycle N+1.
- Throughput is 1 beat per cycle in both modes when out_ready is held at 1.
- SKID=1 adds no latency when the stage is draining. The skid register is used only under backpressure.
- Values after rst, and after the first edge with rst=1:
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0, state EMPTY.
  - in_ready=1 in SKID=1.
  - in_ready=1 in SKID=0 (follows from out_valid=0).
- rst asserted mid-operation discards all held beats and takes effect at that edge.
- out_ctrl is gated combinationally by out_valid, so a squashed instruction can never assert WB/MEM enables downstream.
- No combinational path from out_ready to in_ready when SKID=1. When SKID=0, that path exists by design.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_ctrl=3'b111 -> out_valid=0, out_ctrl=0, out_data=0, both counters 0. First accept after rst deasserts appears one cycle later.
- Streaming, SKID=0 and SKID=1: feed beats with data 1..8 on consecutive cycles with out_ready=1 -> out_data 1..8 on consecutive cycles, each one cycle after input, in_ready constant 1, stall_cnt=0.
- Backpressure, SKID=1: feed beats A, B, C back-to-back while out_ready=0 -> in_ready drops after B is accepted, C is held upstream, stall_cnt counts 1 per cycle. Then raise out_ready -> output order A, B, C with no gaps.
- Flush: state TWO (SKID=1) or FULL (SKID=0), assert flush together with in_valid=1 carrying ctrl=3'b101 -> next cycle out_valid=0, out_ctrl=0, the offered beat is never output, out_data unchanged.
- Bubbles and saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and stays at 15. Flush does not change it; rst returns it to 0.
- Simultaneous accept and drain: state FULL/ONE, in_valid=1, out_ready=1 with data D -> state unchanged and out_data=D on the next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with a valid/ready
// handshake, synchronous flush, an optional two-entry skid mode and
// saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 133,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit USE_SKID = (SKID != 0);

  // ST_ONE doubles as FULL when the skid register is not in use
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              accept;
  logic              drain;

  assign out_valid  = (state_q != ST_EMPTY);
  // Skid mode takes in_ready straight from a flop; otherwise it looks through to out_ready
  assign in_ready   = USE_SKID ? in_ready_q : (!out_valid || out_ready);
  // A squashed or empty slot never presents enables downstream
  assign out_ctrl   = out_valid ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  // A beat offered alongside flush is dropped, so flush masks the accept
  assign accept = in_valid && in_ready && !flush;
  assign drain  = out_valid && out_ready;

  // Next-state and storage steering: flush empties everything but keeps the data
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && (drain || !USE_SKID)) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // Saturating performance counters driven by the pre-edge handshake signals
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, storage and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table-driven bench for pipe_stage_reg, with one
// single-entry instance (default counter width) and one skid instance (4-bit counters).
module tb_pipe_stage_reg;

  localparam int DW = 133;

  typedef struct {
    logic       in_valid;
    logic [2:0] in_ctrl;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic [2:0] exp_out_ctrl;
    logic [7:0] exp_out_data;
    logic [15:0] exp_stall;
    logic [15:0] exp_bubble;
  } vec_t;

  logic clk;
  logic rst;

  logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [2:0]    in_ctrl0, out_ctrl0;
  logic [DW-1:0] in_data0, out_data0;
  logic [15:0]   stall_cnt0, bubble_cnt0;

  logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [2:0]    in_ctrl1, out_ctrl1;
  logic [DW-1:0] in_data1, out_data1;
  logic [3:0]    stall_cnt1, bubble_cnt1;

  int checks;
  int errors;

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
  );

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int v, input int c, input int d, input int r, input int f,
                              input int eir, input int eov, input int eoc, input int eod,
                              input int es, input int eb);
    vec_t t;
    t.in_valid      = 1'(v);
    t.in_ctrl       = 3'(c);
    t.in_data       = 8'(d);
    t.out_ready     = 1'(r);
    t.flush         = 1'(f);
    t.exp_in_ready  = 1'(eir);
    t.exp_out_valid = 1'(eov);
    t.exp_out_ctrl  = 3'(eoc);
    t.exp_out_data  = 8'(eod);
    t.exp_stall     = 16'(es);
    t.exp_bubble    = 16'(eb);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkState(input int sel, input string tag, input vec_t t);
    if (sel == 0) begin
      checkOutput({tag, " out_valid"}, DW'(out_valid0), DW'(t.exp_out_valid));
      checkOutput({tag, " out_ctrl"},  DW'(out_ctrl0),  DW'(t.exp_out_ctrl));
      checkOutput({tag, " out_data"},  out_data0,       DW'(t.exp_out_data));
      checkOutput({tag, " stall_cnt"}, DW'(stall_cnt0), DW'(t.exp_stall));
      checkOutput({tag, " bubble_cnt"}, DW'(bubble_cnt0), DW'(t.exp_bubble));
    end else begin
      checkOutput({tag, " out_valid"}, DW'(out_valid1), DW'(t.exp_out_valid));
      checkOutput({tag, " out_ctrl"},  DW'(out_ctrl1),  DW'(t.exp_out_ctrl));
      checkOutput({tag, " out_data"},  out_data1,       DW'(t.exp_out_data));
      checkOutput({tag, " stall_cnt"}, DW'(stall_cnt1), DW'(t.exp_stall));
      checkOutput({tag, " bubble_cnt"}, DW'(bubble_cnt1), DW'(t.exp_bubble));
    end
  endtask

  // Drive one vector on the selected instance (the other idles), check in_ready before the edge and state after it
  task automatic applyStimulus(input int sel, input string tag, input vec_t t);
    @(negedge clk);
    rst        = 1'b0;
    in_valid0  = (sel == 0) ? t.in_valid  : 1'b0;
    in_ctrl0   = (sel == 0) ? t.in_ctrl   : 3'd0;
    in_data0   = (sel == 0) ? DW'(t.in_data) : '0;
    out_ready0 = (sel == 0) ? t.out_ready : 1'b0;
    flush0     = (sel == 0) ? t.flush     : 1'b0;
    in_valid1  = (sel == 1) ? t.in_valid  : 1'b0;
    in_ctrl1   = (sel == 1) ? t.in_ctrl   : 3'd0;
    in_data1   = (sel == 1) ? DW'(t.in_data) : '0;
    out_ready1 = (sel == 1) ? t.out_ready : 1'b0;
    flush1     = (sel == 1) ? t.flush     : 1'b0;
    #1;
    checkOutput({tag, " in_ready"}, DW'((sel == 0) ? in_ready0 : in_ready1), DW'(t.exp_in_ready));
    @(posedge clk);
    #1;
    checkState(sel, tag, t);
  endtask

  vec_t t0[15];
  vec_t t1[22];

  // Main test sequence
  initial begin
    checks = 0;
    errors = 0;

    // Single-entry instance: streaming, backpressure, accept+drain, flush, drain to empty
    t0[0]  = mk(1, 1, 1, 1, 0,  1, 1, 1, 1, 0, 1);
    t0[1]  = mk(1, 2, 2, 1, 0,  1, 1, 2, 2, 0, 1);
    t0[2]  = mk(1, 3, 3, 1, 0,  1, 1, 3, 3, 0, 1);
    t0[3]  = mk(1, 4, 4, 1, 0,  1, 1, 4, 4, 0, 1);
    t0[4]  = mk(1, 5, 5, 1, 0,  1, 1, 5, 5, 0, 1);
    t0[5]  = mk(1, 6, 6, 1, 0,  1, 1, 6, 6, 0, 1);
    t0[6]  = mk(1, 7, 7, 1, 0,  1, 1, 7, 7, 0, 1);
    t0[7]  = mk(1, 3, 8, 1, 0,  1, 1, 3, 8, 0, 1);
    t0[8]  = mk(0, 0, 0, 0, 0,  0, 1, 3, 8, 1, 1);
    t0[9]  = mk(1, 5, 9, 0, 0,  0, 1, 3, 8, 2, 1);
    t0[10] = mk(1, 5, 9, 1, 0,  1, 1, 5, 9, 2, 1);
    t0[11] = mk(1, 5, 10, 1, 1, 1, 0, 0, 9, 2, 1);
    t0[12] = mk(0, 0, 0, 1, 0,  1, 0, 0, 9, 2, 2);
    t0[13] = mk(1, 6, 11, 0, 0, 1, 1, 6, 11, 2, 2);
    t0[14] = mk(0, 0, 0, 1, 0,  1, 0, 0, 11, 2, 2);

    // Skid instance: streaming, A/B/C under backpressure, flush from TWO and from EMPTY
    t1[0]  = mk(1, 1, 1, 1, 0,  1, 1, 1, 1, 0, 1);
    t1[1]  = mk(1, 2, 2, 1, 0,  1, 1, 2, 2, 0, 1);
    t1[2]  = mk(1, 3, 3, 1, 0,  1, 1, 3, 3, 0, 1);
    t1[3]  = mk(1, 4, 4, 1, 0,  1, 1, 4, 4, 0, 1);
    t1[4]  = mk(1, 5, 5, 1, 0,  1, 1, 5, 5, 0, 1);
    t1[5]  = mk(1, 6, 6, 1, 0,  1, 1, 6, 6, 0, 1);
    t1[6]  = mk(1, 7, 7, 1, 0,  1, 1, 7, 7, 0, 1);
    t1[7]  = mk(1, 3, 8, 1, 0,  1, 1, 3, 8, 0, 1);
    t1[8]  = mk(0, 0, 0, 1, 0,  1, 0, 0, 8, 0, 1);
    t1[9]  = mk(1, 1, 20, 0, 0, 1, 1, 1, 20, 0, 1);
    t1[10] = mk(1, 2, 21, 0, 0, 1, 1, 1, 20, 1, 1);
    t1[11] = mk(1, 4, 22, 0, 0, 0, 1, 1, 20, 2, 1);
    t1[12] = mk(1, 4, 22, 0, 0, 0, 1, 1, 20, 3, 1);
    t1[13] = mk(1, 4, 22, 1, 0, 0, 1, 2, 21, 3, 1);
    t1[14] = mk(1, 4, 22, 1, 0, 1, 1, 4, 22, 3, 1);
    t1[15] = mk(0, 0, 0, 1, 0,  1, 0, 0, 22, 3, 1);
    t1[16] = mk(1, 3, 30, 0, 0, 1, 1, 3, 30, 3, 1);
    t1[17] = mk(1, 5, 31, 0, 0, 1, 1, 3, 30, 4, 1);
    t1[18] = mk(1, 5, 32, 0, 1, 0, 0, 0, 30, 5, 1);
    t1[19] = mk(0, 0, 0, 1, 0,  1, 0, 0, 30, 5, 2);
    t1[20] = mk(1, 5, 33, 0, 1, 1, 0, 0, 30, 5, 2);
    t1[21] = mk(0, 0, 0, 1, 0,  1, 0, 0, 30, 5, 3);

    // Reset held two cycles while a beat with all enables set is offered
    rst = 1'b1;
    flush0 = 1'b0; in_valid0 = 1'b1; in_ctrl0 = 3'b111; in_data0 = DW'(8'hAA); out_ready0 = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b1; in_ctrl1 = 3'b111; in_data1 = DW'(8'hAA); out_ready1 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkState(0, "reset0", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    checkState(1, "reset1", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    checkOutput("reset1 in_ready", DW'(in_ready1), DW'(1'b1));

    for (int i = 0; i < 15; i++) applyStimulus(0, $sformatf("t0[%0d]", i), t0[i]);
    for (int i = 0; i < 22; i++) applyStimulus(1, $sformatf("t1[%0d]", i), t1[i]);

    // Bubble counter saturates at 15 and a flush cycle leaves it there
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, $sformatf("bub[%0d]", i),
                    mk(0, 0, 0, 1, 0, 1, 0, 0, 30, 5, (4 + i > 15) ? 15 : 4 + i));
    end
    applyStimulus(1, "bub_flush", mk(0, 0, 0, 1, 1, 1, 0, 0, 30, 5, 15));

    // Stall counter saturates at 15 while a beat sits under backpressure
    applyStimulus(1, "stall_load", mk(1, 6, 40, 0, 0, 1, 1, 6, 40, 5, 15));
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, $sformatf("stall[%0d]", i),
                    mk(0, 0, 0, 0, 0, 1, 1, 6, 40, (6 + i > 15) ? 15 : 6 + i, 15));
    end

    // Mid-operation reset discards the held beat and clears both instances' counters
    @(negedge clk);
    rst = 1'b1;
    in_valid1 = 1'b1; in_ctrl1 = 3'b111; in_data1 = DW'(8'h55); out_ready1 = 1'b0; flush1 = 1'b0;
    @(posedge clk);
    #1;
    checkState(1, "midrst1", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    checkOutput("midrst1 in_ready", DW'(in_ready1), DW'(1'b1));
    checkState(0, "midrst0", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // First accept after reset appears one cycle later
    applyStimulus(1, "post_rst", mk(1, 2, 50, 1, 0, 1, 1, 2, 50, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
